// File: rtl/dm_wr_sched.sv
// Write-port scheduler for the per-PE data memory.
// Shares one BRAM write port between LOAD, SHIFT, TX streams and ALU write-back.
module dm_wr_sched #(
    parameter int                 DATA_W  = 32,
    parameter int                 ADDR_W  = 8,
    parameter logic [ADDR_W-1:0]  LD_BASE = 8'h00,
    parameter logic [ADDR_W-1:0]  SH_BASE = 8'h20,
    parameter logic [ADDR_W-1:0]  TX_BASE = 8'hA0,
    parameter int                 LD_LEN  = 32,
    parameter int                 SH_LEN  = 32,
    parameter int                 TX_LEN  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              sh_valid,
    input  logic [DATA_W-1:0] sh_data,
    output logic              sh_ready,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [2:0]        clr,
    output logic [2:0]        full,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [1:0]        wr_src,
    output logic [15:0]       stall_cnt
);
    // Handshake: a stream word transfers in a cycle where valid && ready are both
    // high; ready is a combinational grant and never depends on valid of the same
    // stream being held afterwards. Write-back has no ready and is always taken.

    // One extra bit so a counter can hold LEN == 2^ADDR_W.
    localparam int CW = ADDR_W + 1;

    logic [CW-1:0] ld_cnt, sh_cnt, tx_cnt;
    logic [1:0]    rr_ptr;
    logic [2:0]    valid_v, elig, gnt;
    logic [1:0]    p0, p1, p2;
    logic          stall_hit;
    logic [ADDR_W-1:0] ld_addr, sh_addr, tx_addr;

    assign valid_v = {tx_valid, sh_valid, ld_valid};
    assign full[0] = (ld_cnt == CW'(LD_LEN));
    assign full[1] = (sh_cnt == CW'(SH_LEN));
    assign full[2] = (tx_cnt == CW'(TX_LEN));
    assign elig    = valid_v & ~full & ~clr;

    assign ld_addr = LD_BASE + ld_cnt[ADDR_W-1:0];
    assign sh_addr = SH_BASE + sh_cnt[ADDR_W-1:0];
    assign tx_addr = TX_BASE + tx_cnt[ADDR_W-1:0];

    // Search order starts at the stream after the last granted one.
    always_comb begin
        p0 = 2'd0;
        p1 = 2'd1;
        p2 = 2'd2;
        case (rr_ptr)
            2'd0: begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
            2'd1: begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
            default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
        endcase
    end

    always_comb begin
        gnt = 3'b000;
        if (!wb_valid) begin
            if (elig[p0])      gnt[p0] = 1'b1;
            else if (elig[p1]) gnt[p1] = 1'b1;
            else if (elig[p2]) gnt[p2] = 1'b1;
        end
    end

    assign ld_ready  = gnt[0];
    assign sh_ready  = gnt[1];
    assign tx_ready  = gnt[2];
    assign stall_hit = |(valid_v & ~full & ~gnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_src    <= 2'd0;
            ld_cnt    <= '0;
            sh_cnt    <= '0;
            tx_cnt    <= '0;
            rr_ptr    <= 2'd2;
            stall_cnt <= 16'd0;
        end else begin
            wr_en <= wb_valid | (|gnt);
            if (wb_valid) begin
                wr_addr <= wb_addr;
                wr_data <= wb_data;
                wr_src  <= 2'd3;
            end else if (gnt[0]) begin
                wr_addr <= ld_addr;
                wr_data <= ld_data;
                wr_src  <= 2'd0;
                rr_ptr  <= 2'd0;
            end else if (gnt[1]) begin
                wr_addr <= sh_addr;
                wr_data <= sh_data;
                wr_src  <= 2'd1;
                rr_ptr  <= 2'd1;
            end else if (gnt[2]) begin
                wr_addr <= tx_addr;
                wr_data <= tx_data;
                wr_src  <= 2'd2;
                rr_ptr  <= 2'd2;
            end

            // Clear wins over a same-cycle increment (and blocks the grant anyway).
            if (clr[0])      ld_cnt <= '0;
            else if (gnt[0]) ld_cnt <= ld_cnt + 1'b1;
            if (clr[1])      sh_cnt <= '0;
            else if (gnt[1]) sh_cnt <= sh_cnt + 1'b1;
            if (clr[2])      tx_cnt <= '0;
            else if (gnt[2]) tx_cnt <= tx_cnt + 1'b1;

            if (stall_hit && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_dm_wr_sched.sv
// Self-checking bench for dm_wr_sched: scoreboard of expected writes plus
// per-scenario inline checks on handshake, flags and stall counter.
module tb_dm_wr_sched;
    localparam int W = 42;
    localparam logic [31:0] LD_TAG = 32'h1100_0000;
    localparam logic [31:0] SH_TAG = 32'h2200_0000;
    localparam logic [31:0] TX_TAG = 32'h3300_0000;
    localparam logic [31:0] WB_TAG = 32'h4400_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid, sh_valid, tx_valid, wb_valid;
    logic [31:0] ld_data, sh_data, tx_data, wb_data;
    logic        ld_ready, sh_ready, tx_ready;
    logic [7:0]  wb_addr;
    logic [2:0]  clr, full;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  wr_src;
    logic [15:0] stall_cnt;

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int ld_idx, sh_idx, tx_idx;

    dm_wr_sched dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .sh_valid(sh_valid), .sh_data(sh_data), .sh_ready(sh_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .clr(clr), .full(full),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_src(wr_src),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] mk(input logic [1:0] src, input logic [7:0] addr,
                                        input logic [31:0] data);
        return {src, addr, data};
    endfunction

    // Scoreboard: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got src=%0d addr=%h data=%h, required none",
                         wr_src, wr_addr, wr_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({wr_src, wr_addr, wr_data} !== e) begin
                    bad++;
                    $display("FAIL write: got src=%0d addr=%h data=%h, required src=%0d addr=%h data=%h",
                             wr_src, wr_addr, wr_data, e[41:40], e[39:32], e[31:0]);
                end
            end
        end
    end

    task automatic drive_data();
        ld_data = LD_TAG | 32'(ld_idx);
        sh_data = SH_TAG | 32'(sh_idx);
        tx_data = TX_TAG | 32'(tx_idx);
    endtask

    // One clock: record which streams transfer, then advance their data words.
    task automatic step();
        bit fl, fs, ft;
        @(negedge clk);
        fl = ld_valid && ld_ready && !rst;
        fs = sh_valid && sh_ready && !rst;
        ft = tx_valid && tx_ready && !rst;
        @(posedge clk);
        #1;
        if (fl) ld_idx++;
        if (fs) sh_idx++;
        if (ft) tx_idx++;
        drive_data();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic idle_all();
        ld_valid = 0; sh_valid = 0; tx_valid = 0; wb_valid = 0; clr = 3'b000;
    endtask

    task automatic do_reset();
        idle_all();
        wb_addr = 8'h00; wb_data = 32'h0;
        rst = 1'b1;
        ld_idx = 0; sh_idx = 0; tx_idx = 0;
        drive_data();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_drained(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d writes missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outs(input string name);
        total++;
        if ({wr_en, wr_addr, wr_data, wr_src, full, stall_cnt} !== '0) begin
            bad++;
            $display("FAIL %s: got wr_en=%b addr=%h data=%h src=%0d full=%b stall=%0d, required all zero",
                     name, wr_en, wr_addr, wr_data, wr_src, full, stall_cnt);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_outs("reset_outs");
        ld_valid = 1; sh_valid = 1; tx_valid = 1;
        #1;
        total++;
        if ({ld_ready, sh_ready, tx_ready} !== 3'b100) begin
            bad++;
            $display("FAIL reset_first_priority: got ld/sh/tx ready=%b%b%b, required 100",
                     ld_ready, sh_ready, tx_ready);
        end
        idle_all();
    endtask

    task automatic test_ld_only();
        do_reset();
        for (int i = 0; i < 32; i++) exp_q.push_back(mk(2'd0, 8'(i), LD_TAG | 32'(i)));
        ld_valid = 1;
        steps(34);
        total++;
        if (full !== 3'b001 || ld_ready !== 1'b0) begin
            bad++;
            $display("FAIL ld_full: got full=%b ld_ready=%b, required full=001 ld_ready=0", full, ld_ready);
        end
        total++;
        if (stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL ld_stall: got %0d, required 0", stall_cnt);
        end
        idle_all();
        steps(2);
        check_drained("ld_only");
    endtask

    task automatic test_round_robin_and_wb();
        logic [15:0] s0;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk(2'd0, 8'h00 + 8'(i), LD_TAG | 32'(i)));
            exp_q.push_back(mk(2'd1, 8'h20 + 8'(i), SH_TAG | 32'(i)));
            exp_q.push_back(mk(2'd2, 8'hA0 + 8'(i), TX_TAG | 32'(i)));
        end
        ld_valid = 1; sh_valid = 1; tx_valid = 1;
        steps(6);
        total++;
        if (stall_cnt !== 16'd6) begin
            bad++;
            $display("FAIL rr_stall: got %0d, required 6", stall_cnt);
        end
        // Write-back burst while all streams keep requesting.
        s0 = stall_cnt;
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1;
            wb_addr  = 8'h40 + 8'(i);
            wb_data  = WB_TAG | 32'(i);
            exp_q.push_back(mk(2'd3, wb_addr, wb_data));
            #1;
            total++;
            if ({ld_ready, sh_ready, tx_ready} !== 3'b000) begin
                bad++;
                $display("FAIL wb_ready: got ld/sh/tx ready=%b%b%b, required 000",
                         ld_ready, sh_ready, tx_ready);
            end
            step();
        end
        wb_valid = 0;
        total++;
        if (stall_cnt !== s0 + 16'd3) begin
            bad++;
            $display("FAIL wb_stall: got %0d, required %0d", stall_cnt, s0 + 16'd3);
        end
        exp_q.push_back(mk(2'd0, 8'h02, LD_TAG | 32'd2));
        exp_q.push_back(mk(2'd1, 8'h22, SH_TAG | 32'd2));
        exp_q.push_back(mk(2'd2, 8'hA2, TX_TAG | 32'd2));
        steps(3);
        idle_all();
        steps(2);
        check_drained("rr_wb");
    endtask

    task automatic test_clear_vs_grant();
        do_reset();
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(2'd2, 8'hA0 + 8'(i), TX_TAG | 32'(i)));
        tx_valid = 1;
        steps(5);
        clr = 3'b100;
        #1;
        total++;
        if (tx_ready !== 1'b0) begin
            bad++;
            $display("FAIL clr_ready: got tx_ready=%b, required 0", tx_ready);
        end
        step();
        clr = 3'b000;
        exp_q.push_back(mk(2'd2, 8'hA0, TX_TAG | 32'd5));
        step();
        idle_all();
        steps(2);
        check_drained("clr_grant");
    endtask

    task automatic test_full_reclear();
        do_reset();
        for (int i = 0; i < 32; i++) exp_q.push_back(mk(2'd1, 8'h20 + 8'(i), SH_TAG | 32'(i)));
        sh_valid = 1;
        steps(34);
        total++;
        if (full[1] !== 1'b1 || sh_ready !== 1'b0) begin
            bad++;
            $display("FAIL sh_full: got full=%b sh_ready=%b, required full[1]=1 sh_ready=0", full, sh_ready);
        end
        steps(2);
        total++;
        if (sh_ready !== 1'b0) begin
            bad++;
            $display("FAIL sh_full_hold: got sh_ready=%b, required 0", sh_ready);
        end
        clr = 3'b010;
        step();
        clr = 3'b000;
        #1;
        total++;
        if (full[1] !== 1'b0) begin
            bad++;
            $display("FAIL sh_reclear: got full=%b, required full[1]=0", full);
        end
        exp_q.push_back(mk(2'd1, 8'h20, SH_TAG | 32'd32));
        step();
        idle_all();
        steps(2);
        check_drained("full_reclear");
    endtask

    task automatic test_midop_reset();
        do_reset();
        for (int i = 0; i < 10; i++) exp_q.push_back(mk(2'd0, 8'(i), LD_TAG | 32'(i)));
        ld_valid = 1;
        steps(10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outs("midop_reset_outs");
        ld_idx = 0;
        drive_data();
        exp_q.push_back(mk(2'd0, 8'h00, LD_TAG));
        step();
        idle_all();
        steps(2);
        check_drained("midop_reset");
    endtask

    initial begin
        test_reset();
        test_ld_only();
        test_round_robin_and_wb();
        test_clear_vs_grant();
        test_full_reclear();
        test_midop_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dm_wr_sched.md
# dm_wr_sched

Write-port scheduler for the per-PE data memory. It shares the single BRAM write port between four producers: LOAD, SHIFT, TX and the ALU write-back. Each of the three streaming producers writes sequentially into its own fixed address region through an auto-incrementing counter. Write-back carries an explicit destination address, always wins arbitration and never stalls.

## Interface
Parameters:
- DATA_W, 32, write data width (complex sample, 2x16)
- ADDR_W, 8, data memory address width
- LD_BASE, 8'h00, LOAD region base address
- SH_BASE, 8'h20, SHIFT region base address
- TX_BASE, 8'hA0, TX region base address
- LD_LEN, 32, LOAD region depth in words (1..2^ADDR_W)
- SH_LEN, 32, SHIFT region depth in words
- TX_LEN, 32, TX region depth in words

Ports:
- clk, in, 1, clock
- rst, in, 1, reset: synchronous, active-high
- ld_valid / sh_valid / tx_valid, in, 1 each, stream word offered
- ld_data / sh_data / tx_data, in, DATA_W each, stream word
- ld_ready / sh_ready / tx_ready, out, 1 each, combinational grant; a transfer occurs when valid && ready
- wb_valid, in, 1, write-back request; always accepted
- wb_addr, in, ADDR_W, write-back destination
- wb_data, in, DATA_W, write-back data
- clr, in, 3, per-stream region clear: bit0 LD, bit1 SH, bit2 TX
- full, out, 3, per-stream region-full flags, same bit order as clr
- wr_en, out, 1, BRAM write enable (registered)
- wr_addr, out, ADDR_W, BRAM write address (registered)
- wr_data, out, DATA_W, BRAM write data (registered)
- wr_src, out, 2, source of the current write: 0 LD, 1 SH, 2 TX, 3 WB (registered)
- stall_cnt, out, 16, saturating count of cycles in which a stream was valid but not granted

## Operation
- Each stream i has a counter cnt_i in 0..LEN_i. The stream's write address is (BASE_i + cnt_i) mod 2^ADDR_W.
- eligible_i = valid_i && !full_i && !clr_i.
- Arbitration is evaluated every cycle:
  - If wb_valid is high, WB is granted and all ready outputs are 0.
  - Otherwise, round-robin among eligible streams, starting at the stream after rr_ptr.
  - Exactly one grant is issued per cycle; with no requesters there is no grant.
- rr_ptr updates only on a stream grant, to the index of the granted stream. It is unchanged on a WB grant or an idle cycle.
- On a stream transfer, cnt_i increments by 1. When cnt_i reaches LEN_i, full_i becomes 1 and the stream stays ineligible until cleared.
- clr_i sets cnt_i to 0 and full_i to 0, and takes precedence over a same-cycle increment. ready_i is 0 during a clr_i cycle.
- A WB transfer does not touch any counter.
- stall_cnt increments by 1 in any cycle where some valid_i && !full_i stream is not granted, including cycles blocked by WB. It saturates at 16'hFFFF and is cleared only by rst.
- Write-back addresses inside a stream region are legal and are written unchecked. Ordering against stream writes is the issuer's responsibility.

## Timing
- Write latency is 1 cycle: a grant in cycle N drives wr_en=1 with the matching wr_addr, wr_data and wr_src in cycle N+1.
- With no grant in cycle N, wr_en=0 in cycle N+1. wr_addr, wr_data and wr_src hold their previous values.
- ready outputs are combinational from valid, wb_valid, full, clr and rr_ptr. They have no dependency on the registered outputs.
- full_i rises in the cycle after the transfer that makes cnt_i equal LEN_i.
- Throughput is one write per cycle. A continuous wb_valid starves all streams indefinitely, by design.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, wr_src=0, full=3'b000, stall_cnt=0, all cnt_i=0, rr_ptr=TX so that LD has first priority.
- rst asserted mid-stream discards any in-flight grant. wr_en is 0 in the cycle after rst.

## Test plan
- LD only: after reset, hold ld_valid with 32 distinct words -> 32 writes to 0x00..0x1F with wr_src=0. full[0] rises after the 32nd write and ld_ready=0 thereafter.
- Round-robin: ld, sh and tx valid together from reset -> grant order LD, SH, TX, LD, ...; first writes go to 0x00, 0x20, 0xA0, 0x01.
- WB priority: hold all streams valid and pulse wb_valid for 3 cycles with wb_addr=0x40..0x42 -> writes to 0x40..0x42 with wr_src=3, no stream ready, stall_cnt +3. Round-robin then resumes at the stream after the last one granted.
- Clear vs grant: tx_valid with cnt=5 and clr[2] in the same cycle -> no TX write that cycle. The next TX write goes to 0xA0.
- Full and reclear: fill SH (32 writes, last to 0x3F) -> full[1]=1 and sh_ready stays 0 while sh_valid is held. Pulse clr[1] -> the next SH write goes to 0x20.
- Mid-op reset: assert rst during a continuous LD burst at cnt=10 -> wr_en=0 next cycle and all outputs at reset values. The next LD write after rst goes to 0x00.
